// File: rtl/reg_file_mp_pkg.sv
// Shared types, constants and helpers for the multi-port register file.
package rf_pkg;
    localparam int RF_DEPTH   = 32;
    localparam int RF_WIDTH   = 32;
    localparam int RF_AW      = $clog2(RF_DEPTH);
    localparam int MAX_WPORTS = 8;

    typedef logic [RF_AW-1:0]    rf_addr_t;
    typedef logic [RF_WIDTH-1:0] rf_data_t;

    localparam rf_addr_t ZERO_ADDR = '0;

    // Highest-index set bit of a write-port hit vector, or -1 when no port hits.
    function automatic int rf_wr_select(input logic [MAX_WPORTS-1:0] hit);
        int sel;
        sel = -1;
        for (int i = 0; i < MAX_WPORTS; i++) begin
            if (hit[i]) sel = i;
        end
        return sel;
    endfunction
endpackage

// File: rtl/reg_file_mp_if.sv
// Write, read and scoreboard signals of the register file, grouped as one bus.
interface reg_file_mp_if #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NWRITE-1:0]           wr_en;
    logic [NWRITE-1:0][AW-1:0]   wr_addr;
    logic [NWRITE-1:0][WIDTH-1:0] wr_data;
    logic [NREAD-1:0][AW-1:0]    rd_addr;
    logic [NREAD-1:0][WIDTH-1:0] rd_data;
    logic [NREAD-1:0]            rd_busy;
    logic                        sb_set;
    logic [AW-1:0]               sb_addr;
    logic [DEPTH-1:0]            busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr,
        input  rd_data, rd_busy, busy_vec
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/reg_file_mp_bypass_mux.sv
// Per-read-port select: zero entry, same-cycle write forwarding, or stored array value.
module rf_bypass_mux
    import rf_pkg::*;
#(
    parameter int AW       = 5,
    parameter int WIDTH    = 32,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]              rd_addr,
    input  logic [NWRITE-1:0]          wr_en,
    input  logic [NWRITE-1:0][AW-1:0]  wr_addr,
    input  logic [NWRITE-1:0][WIDTH-1:0] wr_data,
    input  logic                       sb_set,
    input  logic [AW-1:0]              sb_addr,
    input  logic [WIDTH-1:0]           arr_data,
    input  logic                       arr_busy,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_busy
);
    logic [MAX_WPORTS-1:0] hit;
    logic [WIDTH-1:0]      fwd_data;
    logic                  is_zero;
    int                    sel;

    always_comb begin
        hit = '0;
        for (int p = 0; p < NWRITE; p++) begin
            hit[p] = wr_en[p] && (wr_addr[p] == rd_addr);
        end
        sel = rf_wr_select(hit);
        fwd_data = '0;
        for (int p = 0; p < NWRITE; p++) begin
            if (p == sel) fwd_data = wr_data[p];
        end
        is_zero = (ZERO_REG != 0) && (rd_addr == AW'(ZERO_ADDR));

        // A retiring write clears busy unless a new producer issues to the same register.
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if ((BYPASS != 0) && (sel >= 0)) begin
            rd_data = fwd_data;
            rd_busy = sb_set && (sb_addr == rd_addr);
        end else begin
            rd_data = arr_data;
            rd_busy = arr_busy;
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-entry busy scoreboard for issue/writeback hazard checks.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int WIDTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         reset_n,
    reg_file_mp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;

    // Later ports are assigned last, so the highest index wins an address conflict;
    // the set is applied after the clears so a same-cycle issue keeps the entry busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            for (int p = 0; p < NWRITE; p++) begin
                if (bus.wr_en[p] && !((ZERO_REG != 0) && (bus.wr_addr[p] == '0))) begin
                    mem[bus.wr_addr[p]]  <= bus.wr_data[p];
                    busy[bus.wr_addr[p]] <= 1'b0;
                end
            end
            if (bus.sb_set && !((ZERO_REG != 0) && (bus.sb_addr == '0))) begin
                busy[bus.sb_addr] <= 1'b1;
            end
        end
    end

    assign bus.busy_vec = busy;

    for (genvar r = 0; r < NREAD; r++) begin : g_rd
        logic [WIDTH-1:0] mux_data;
        logic             mux_busy;

        rf_bypass_mux #(
            .AW       (AW),
            .WIDTH    (WIDTH),
            .NWRITE   (NWRITE),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_mux (
            .rd_addr  (bus.rd_addr[r]),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .sb_set   (bus.sb_set),
            .sb_addr  (bus.sb_addr),
            .arr_data (mem[bus.rd_addr[r]]),
            .arr_busy (busy[bus.rd_addr[r]]),
            .rd_data  (mux_data),
            .rd_busy  (mux_busy)
        );

        // Forwarded write data must not leak out while reset is held.
        assign bus.rd_data[r] = reset_n ? mux_data : '0;
        assign bus.rd_busy[r] = reset_n && mux_busy;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Two register-file configurations driven in lockstep and checked against a behavioural model.
module tb_reg_file_mp;
    import rf_pkg::*;

    localparam int NR = 4;
    localparam int NW = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NW-1:0]       wr_en = '0;
    logic [NW-1:0][4:0]  wr_addr = '0;
    logic [NW-1:0][31:0] wr_data = '0;
    logic [NR-1:0][4:0]  rd_addr = '0;
    logic                sb_set = 1'b0;
    logic [4:0]          sb_addr = '0;

    int  errors = 0;
    int  checks = 0;
    bit  check_en = 1'b0;

    reg_file_mp_if #(.DEPTH(32), .WIDTH(32), .NREAD(NR), .NWRITE(NW)) bus_a ();
    reg_file_mp_if #(.DEPTH(32), .WIDTH(32), .NREAD(NR), .NWRITE(NW)) bus_b ();

    assign bus_a.wr_en = wr_en;   assign bus_b.wr_en = wr_en;
    assign bus_a.wr_addr = wr_addr; assign bus_b.wr_addr = wr_addr;
    assign bus_a.wr_data = wr_data; assign bus_b.wr_data = wr_data;
    assign bus_a.rd_addr = rd_addr; assign bus_b.rd_addr = rd_addr;
    assign bus_a.sb_set = sb_set; assign bus_b.sb_set = sb_set;
    assign bus_a.sb_addr = sb_addr; assign bus_b.sb_addr = sb_addr;

    // dut_a: zero entry + bypass; dut_b: plain entry 0, no bypass
    reg_file_mp #(.DEPTH(32), .WIDTH(32), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    reg_file_mp #(.DEPTH(32), .WIDTH(32), .NREAD(NR), .NWRITE(NW), .ZERO_REG(0), .BYPASS(0))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    logic [31:0] m_mem [2][32];
    bit          m_busy [2][32];

    function automatic bit zr(input int k);
        return k == 0;
    endfunction

    function automatic bit bp(input int k);
        return k == 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected read for configuration k at address a, given the inputs currently applied.
    function automatic void model_rd(input int k, input logic [4:0] a,
                                     output logic [31:0] d, output logic b);
        bit          found;
        logic [31:0] fd;
        found = 1'b0;
        fd = '0;
        for (int p = 0; p < NW; p++) begin
            if (wr_en[p] && wr_addr[p] == a) begin
                found = 1'b1;
                fd = wr_data[p];
            end
        end
        if (!reset_n || (zr(k) && a == 5'd0)) begin
            d = '0;
            b = 1'b0;
        end else if (bp(k) && found) begin
            d = fd;
            b = sb_set && (sb_addr == a);
        end else begin
            d = m_mem[k][a];
            b = m_busy[k][a];
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i] = '0;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                for (int p = 0; p < NW; p++) begin
                    if (wr_en[p] && !(zr(k) && wr_addr[p] == 5'd0)) begin
                        m_mem[k][wr_addr[p]] = wr_data[p];
                        m_busy[k][wr_addr[p]] = 1'b0;
                    end
                end
                if (sb_set && !(zr(k) && sb_addr == 5'd0)) m_busy[k][sb_addr] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] vec;
                for (int i = 0; i < 32; i++) vec[i] = reset_n && m_busy[k][i];
                chk($sformatf("busy_vec d%0d", k), (k == 0) ? bus_a.busy_vec : bus_b.busy_vec, vec);
                for (int r = 0; r < NR; r++) begin
                    logic [31:0] ed;
                    logic        eb;
                    model_rd(k, rd_addr[r], ed, eb);
                    chk($sformatf("rd_data d%0d p%0d a%0d", k, r, rd_addr[r]),
                        (k == 0) ? bus_a.rd_data[r] : bus_b.rd_data[r], ed);
                    chk($sformatf("rd_busy d%0d p%0d a%0d", k, r, rd_addr[r]),
                        {31'd0, (k == 0) ? bus_a.rd_busy[r] : bus_b.rd_busy[r]}, {31'd0, eb});
                end
            end
        end
    end

    task automatic idle();
        wr_en = '0;
        sb_set = 1'b0;
        rd_addr = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_en = 1'b1;

        @(negedge clk);
        chk("reset busy_vec a", bus_a.busy_vec, 32'h0);
        chk("reset busy_vec b", bus_b.busy_vec, 32'h0);
        chk("reset rd_data b", bus_b.rd_data[0], 32'h0);
        next();

        // basic write then read; entry 0 behaviour per configuration
        idle(); wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        @(negedge clk); next();
        idle(); rd_addr[0] = 5'd5; wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'h1;
        @(negedge clk);
        chk("basic a", bus_a.rd_data[0], 32'hDEADBEEF);
        chk("basic b", bus_b.rd_data[0], 32'hDEADBEEF);
        next();
        idle(); rd_addr[0] = 5'd0;
        @(negedge clk);
        chk("zero reg a", bus_a.rd_data[0], 32'h0);
        chk("zero reg b", bus_b.rd_data[0], 32'h1);
        next();

        // write conflict: highest port wins
        idle(); wr_en = 3'b011; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
        wr_data[0] = 32'h11; wr_data[1] = 32'h22;
        @(negedge clk); next();
        idle(); rd_addr[2] = 5'd7;
        @(negedge clk);
        chk("conflict a", bus_a.rd_data[2], 32'h22);
        chk("conflict b", bus_b.rd_data[2], 32'h22);
        next();

        // same-cycle forwarding
        idle(); rd_addr[1] = 5'd3; wr_en[2] = 1'b1; wr_addr[2] = 5'd3; wr_data[2] = 32'hA5A5;
        @(negedge clk);
        chk("bypass a", bus_a.rd_data[1], 32'hA5A5);
        chk("bypass b old", bus_b.rd_data[1], 32'h0);
        next();
        idle(); rd_addr[1] = 5'd3;
        @(negedge clk);
        chk("bypass b new", bus_b.rd_data[1], 32'hA5A5);
        next();

        // scoreboard set, writeback clear, set-wins
        idle(); rd_addr[3] = 5'd9; sb_set = 1'b1; sb_addr = 5'd9;
        @(negedge clk);
        chk("sb before a", {31'd0, bus_a.rd_busy[3]}, 32'd0);
        next();
        idle(); rd_addr[3] = 5'd9; wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h99;
        @(negedge clk);
        chk("sb wb a", {31'd0, bus_a.rd_busy[3]}, 32'd0);
        chk("sb wb b", {31'd0, bus_b.rd_busy[3]}, 32'd1);
        chk("sb vec b", {31'd0, bus_b.busy_vec[9]}, 32'd1);
        next();
        idle(); rd_addr[3] = 5'd9; sb_set = 1'b1; sb_addr = 5'd9;
        wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h77;
        @(negedge clk);
        chk("sb setwin fwd a", {31'd0, bus_a.rd_busy[3]}, 32'd1);
        chk("sb cleared b", {31'd0, bus_b.rd_busy[3]}, 32'd0);
        next();
        idle(); rd_addr[3] = 5'd9; sb_set = 1'b1; sb_addr = 5'd0;
        @(negedge clk);
        chk("sb setwin a", {31'd0, bus_a.rd_busy[3]}, 32'd1);
        chk("sb setwin b", {31'd0, bus_b.rd_busy[3]}, 32'd1);
        chk("sb data b", bus_b.rd_data[3], 32'h77);
        next();
        idle();
        @(negedge clk);
        chk("sb zero a", {31'd0, bus_a.busy_vec[0]}, 32'd0);
        chk("sb zero b", {31'd0, bus_b.busy_vec[0]}, 32'd1);
        next();

        // random traffic; narrow address window half the time to provoke aliasing
        for (int i = 0; i < 10000; i++) begin
            idle();
            for (int p = 0; p < NW; p++) begin
                wr_en[p] = ($urandom_range(0, 3) != 0);
                wr_addr[p] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
                wr_data[p] = $urandom;
            end
            for (int r = 0; r < NR; r++) begin
                rd_addr[r] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            end
            sb_set = ($urandom_range(0, 1) != 0);
            sb_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            @(negedge clk);
            next();
        end

        // asynchronous reset mid-cycle with writes and issue in flight
        idle(); wr_en = 3'b111;
        for (int p = 0; p < NW; p++) begin
            wr_addr[p] = 5'(p + 1);
            wr_data[p] = 32'hCAFE0000 | 32'(p + 1);
            rd_addr[p] = 5'(p + 1);
        end
        rd_addr[3] = 5'd4; sb_set = 1'b1; sb_addr = 5'd1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst busy_vec a", bus_a.busy_vec, 32'h0);
        chk("rst busy_vec b", bus_b.busy_vec, 32'h0);
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("rst rd_data a p%0d", r), bus_a.rd_data[r], 32'h0);
            chk($sformatf("rst rd_data b p%0d", r), bus_b.rd_data[r], 32'h0);
            chk($sformatf("rst rd_busy a p%0d", r), {31'd0, bus_a.rd_busy[r]}, 32'd0);
        end
        @(negedge clk);
        next();
        reset_n = 1'b1;
        idle();
        for (int a = 0; a < 32; a += NR) begin
            for (int r = 0; r < NR; r++) rd_addr[r] = 5'(a + r);
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                chk($sformatf("post rst a a%0d", a + r), bus_a.rd_data[r], 32'h0);
                chk($sformatf("post rst b a%0d", a + r), bus_b.rd_data[r], 32'h0);
            end
            next();
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
